hazard_stall_ctrl: RTL
======================

# hazard_stall_ctrl

Decode-stage stall generator for the 5-stage MIPS pipeline; it is the producer-side counterpart of the forwarding selects. It keeps a shadow of the destination register and remaining result latency (Tnew) for the instructions in E and M. It compares these against the D-stage source registers and their latest-use times (Tuse). It stalls D and injects an E bubble whenever forwarding cannot yet deliver a value. It also runs the mult/div busy counter that holds HI/LO users in D.

## Interface
- MULT_CYCLES, 5, E-stage occupancy of mult/multu in cycles (1..15)
- DIV_CYCLES, 10, E-stage occupancy of div/divu in cycles (1..15)

- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  synchronous, active-high
- d_valid  in  1  D holds a real instruction (0 = bubble)
- d_rs  in  5  D source rs
- d_rt  in  5  D source rt
- d_tuse_rs  in  2  cycles until rs is consumed (0 = branch/jr in D, 1 = E use, 2 = M use as store data, 3 = not read)
- d_tuse_rt  in  2  same encoding for rt
- d_dst  in  5  D destination register (0 = no write)
- d_tnew  in  2  cycles after entering E before result is forwardable (0 = jal/bgezal link, 1 = ALU, 2 = load)
- d_md_start  in  1  D is mult/multu/div/divu
- d_md_div  in  1  with d_md_start: 1 = div, 0 = mult
- d_md_use  in  1  D is mfhi/mflo/mthi/mtlo/mult/div
- stall  out  1  freeze PC and IF/ID register
- flush_E  out  1  clear ID/EX register (bubble)
- md_busy  out  1  mult/div unit occupied
- e_dst, m_dst  out  5 each  shadow destination registers (debug/trace)

## Operation
- Shadow state: E entry {e_dst, e_tnew}, M entry {m_dst, m_tnew}. W needs no entry, since W results always have Tnew 0.
- Each rising edge (reset low):
  - M ← {e_dst, sat(e_tnew−1)}, where sat floors at 0.
  - E ← {d_dst, d_tnew} if d_valid and not stall; otherwise E ← {0, 0}.
- Register stall for source s ∈ {rs, rt} with Tuse u, evaluated only when s≠0 and u≠3:
  - If e_dst==s, then stall_s = (e_tnew > u). M is not checked, because E is younger and wins.
  - Otherwise, if m_dst==s, then stall_s = (m_tnew > u).
  - Otherwise stall_s = 0.
- MD counter, 4-bit md_cnt:
  - On an edge with d_md_start & d_valid & ~stall, md_cnt ← DIV_CYCLES if d_md_div, else MULT_CYCLES.
  - Otherwise, if md_cnt≠0, md_cnt decrements.
  - md_busy = (md_cnt≠0).
- md stall = d_valid & d_md_use & md_busy.
- stall = ~reset & d_valid & (stall_rs | stall_rt | md stall).
- flush_E = stall.
- A stalled md_start does not load the counter. It is issued on the first non-stalled edge.
- d_dst==0 never creates a hazard. A write to $0 is not recorded as a producer match, because s≠0 is required.

## Timing
- stall and flush_E are combinational from the D inputs and registered shadow state, valid within the same cycle.
- Shadow entries, md_cnt and md_busy update one edge after the condition.
- md_busy rises the cycle after issue and stays high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
- Reset edge:
  - e_dst=m_dst=0, e_tnew=m_tnew=0, md_cnt=0, so md_busy=0 from the next cycle.
  - stall=flush_E=0 while reset is high.
- Reset mid-divide aborts the count. No stall follows.
- Load-use hazards:
  - ALU user (Tuse 1): 1 stall cycle.
  - Branch user (Tuse 0): 2 stall cycles.
- ALU-result branch user (Tuse 0): 1 stall cycle.
- Store data (Tuse 2): never stalls.

## Test plan
- Load-use: lw $2 (tnew 2) issued, then addu $3,$2,$4 (rs=2, tuse 1) in D -> stall=flush_E=1 for exactly 1 cycle, e_dst=0 in the bubble cycle, then addu issues.
- Load-branch: lw $2, then beq $2,$0 (tuse_rs 0) -> stall for 2 consecutive cycles, released when lw reaches W. Store variant sw $2 (tuse_rt 2) after lw $2 -> stall=0.
- ALU-branch: addu $5 then beq $5,$6 -> 1 stall cycle. addu $5 then addu $7,$5,$5 -> stall=0.
- Priority/zero:
  - E holds jal ($31, tnew 0), M holds lw $31 (tnew 1), D jr $31 (tuse 0) -> stall=0.
  - lw $0 followed by beq $0 -> stall=0.
- Mult/div:
  - mult issued, then mflo next in D -> stall for 5 cycles, md_busy high 5 cycles.
  - div then mfhi -> 10 cycles.
  - Back-to-back mult while busy -> second mult stalls until md_busy=0.
- Reset mid-op: div issued, reset asserted 3 cycles later -> md_busy=0 and e_dst=m_dst=0 the following cycle, and a subsequent mflo with d_valid=1 -> stall=0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage hazard/stall generator: tracks E/M producer latency and the
// mult/div busy counter, and holds D (bubbling E) when forwarding cannot help.
module hazard_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_valid,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_dst,
  input  logic [1:0] d_tnew,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_md_use,
  output logic       stall,
  output logic       flush_E,
  output logic       md_busy,
  output logic [4:0] e_dst,
  output logic [4:0] m_dst
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned TNEW_W = 2;
  localparam int unsigned CNT_W  = 4;
  localparam logic [TNEW_W-1:0] TUSE_NONE = TNEW_W'(3);

  logic [TNEW_W-1:0] e_tnew;
  logic [TNEW_W-1:0] m_tnew;
  logic [CNT_W-1:0]  md_cnt;
  logic              stall_rs;
  logic              stall_rt;
  logic              stall_md;
  logic              issue;
  logic              md_issue;

  // The youngest matching producer decides; $0 and unread sources never hazard.
  function automatic logic src_stall(
    input logic [REG_W-1:0]  src,
    input logic [TNEW_W-1:0] tuse,
    input logic [REG_W-1:0]  edst,
    input logic [TNEW_W-1:0] etnew,
    input logic [REG_W-1:0]  mdst,
    input logic [TNEW_W-1:0] mtnew
  );
    logic hz;
    hz = 1'b0;
    if (src != '0 && tuse != TUSE_NONE) begin
      if (edst == src) begin
        hz = (etnew > tuse);
      end else if (mdst == src) begin
        hz = (mtnew > tuse);
      end
    end
    return hz;
  endfunction

  // Same-cycle stall decision from D inputs and registered shadow state.
  always_comb begin
    stall_rs = src_stall(d_rs, d_tuse_rs, e_dst, e_tnew, m_dst, m_tnew);
    stall_rt = src_stall(d_rt, d_tuse_rt, e_dst, e_tnew, m_dst, m_tnew);
    stall_md = d_valid & d_md_use & md_busy;
    stall    = ~reset & d_valid & (stall_rs | stall_rt | stall_md);
  end

  assign flush_E  = stall;
  assign md_busy  = (md_cnt != '0);
  assign issue    = d_valid & ~stall;
  assign md_issue = issue & d_md_start;

  // Shadow of E/M destinations; a stalled or empty D becomes an E bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_dst  <= '0;
      e_tnew <= '0;
      m_dst  <= '0;
      m_tnew <= '0;
    end else begin
      m_dst  <= e_dst;
      m_tnew <= (e_tnew != '0) ? e_tnew - TNEW_W'(1) : '0;
      if (issue) begin
        e_dst  <= d_dst;
        e_tnew <= d_tnew;
      end else begin
        e_dst  <= '0;
        e_tnew <= '0;
      end
    end
  end

  // Mult/div occupancy counter, loaded only when the md op actually issues.
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (md_issue) begin
      md_cnt <= d_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (md_busy) begin
      md_cnt <= md_cnt - CNT_W'(1);
    end
  end

endmodule
